// File: rtl/bus_dma_master.sv
// Byte-copy bus initiator: reads SRC+i, parks the bus, writes DST+i, one byte every 3 cycles.
// Bus outputs are registered from the next state and gated by BUS_GNT so nothing is driven without grant.
module bus_dma_master #(
  parameter logic [7:0] PARK_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic [7:0] SRC_ADDR,
  input  logic [7:0] DST_ADDR,
  input  logic [7:0] LEN,
  output logic       BUSY,
  output logic       DONE,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Assertion is immediate, release is aligned to CLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] rdbuf_q, rdbuf_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rdbuf_d = rdbuf_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            src_d   = SRC_ADDR;
            dst_d   = DST_ADDR;
            len_d   = LEN;
            idx_d   = 8'd0;
          end
        end
      end
      S_REQ: begin
        if (BUS_GNT) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        state_d = BUS_GNT ? S_RD_DATA : S_REQ;
      end
      S_RD_DATA: begin
        if (BUS_GNT) begin
          state_d = S_WR;
          rdbuf_d = BUS_DATA;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WR: begin
        // Losing grant here drops the write; the byte is re-read after re-grant.
        if (!BUS_GNT) begin
          state_d = S_REQ;
        end else if (idx_q == len_q - 8'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD_ADDR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_d  = (state_d == S_REQ) || (state_d == S_RD_ADDR) ||
             (state_d == S_RD_DATA) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
    case (state_d)
      S_RD_ADDR: addr_d = src_d + idx_d;
      S_RD_DATA: addr_d = PARK_ADDR;
      S_WR:      addr_d = dst_d + idx_d;
      default:   addr_d = 8'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      rdbuf_q <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rdbuf_q <= rdbuf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign BUS_REQ  = req_q;
  assign BUS_ADDR = BUS_GNT ? addr_q : 8'd0;
  assign BUS_WE   = we_q & BUS_GNT;
  assign BUS_DATA = ((state_q == S_WR) && BUS_GNT) ? rdbuf_q : 8'hZZ;

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Bus initiator that block-copies bytes between addresses on the shared 8-bit BUS_DATA/BUS_ADDR/BUS_WE bus.
- Reads from and writes to the registered-read, single-port bus responders (RAM and peripherals) already on that bus.
- Obtains the bus from the arbiter through BUS_REQ/BUS_GNT; is started by the processor through START.
- Copies LEN bytes from SRC_ADDR.. to DST_ADDR.., one byte every 3 cycles.

Parameters:
- PARK_ADDR, 8'hFF, turnaround address driven during the read-data cycle; no responder may decode it.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; sampled only in IDLE.
- SRC_ADDR  in  8  first source address; captured on START.
- DST_ADDR  in  8  first destination address; captured on START.
- LEN  in  8  byte count; captured on START; 0 = no transfer.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- BUS_REQ  out  1  bus request to the arbiter.
- BUS_GNT  in  1  grant from the arbiter; the master owns the bus only while high.
- BUS_ADDR  out  8  address; 0 when not owning the bus.
- BUS_WE  out  1  write enable; 0 when not owning the bus.
- BUS_DATA  inout  8  driven only in WR while granted, otherwise 8'hZZ.

Behaviour:
- Reset: all outputs low, BUS_DATA Z, state IDLE, counters 0. Async assert, sync release.
- Registers: src_r, dst_r, len_r, idx (8b), rdbuf (8b). All bus outputs are registered except the BUS_DATA tristate enable, which is state-decoded.
- IDLE:
  - START with LEN=0 -> DONE_ST, no bus activity.
  - START with LEN>0 -> capture SRC_ADDR, DST_ADDR and LEN, idx=0, go to REQ.
- REQ: BUS_REQ=1, bus outputs idle. When BUS_GNT=1 -> RD_ADDR.
- RD_ADDR: BUS_ADDR=src_r+idx (mod 256), BUS_WE=0. The responder registers its read.
- RD_DATA:
  - BUS_ADDR=PARK_ADDR, BUS_WE=0.
  - The responder drives Mem[src] this cycle; rdbuf is captured at the closing edge.
  - The PARK address makes the responder release BUS_DATA in the next cycle, so there is no contention in WR.
- WR: BUS_ADDR=dst_r+idx (mod 256), BUS_WE=1, BUS_DATA=rdbuf.
  - If idx==len_r-1 -> DONE_ST.
  - Otherwise idx+1 -> RD_ADDR.
- DONE_ST: DONE=1 for exactly one cycle, BUS_REQ=0, BUSY=0 next cycle -> IDLE.
- BUS_REQ stays high from REQ through WR. It drops in the DONE_ST cycle.
- Grant loss: if BUS_GNT=0 in any of RD_ADDR, RD_DATA or WR:
  - Bus outputs are forced idle that cycle (addr 0, WE 0, data Z).
  - The state returns to REQ with idx unchanged.
  - The current byte restarts from RD_ADDR after re-grant.
  - A write is never issued without grant.
- START while not IDLE is ignored.
- Addresses wrap 8'hFF -> 8'h00. Overlapping src/dst ranges copy forward byte by byte with no hazard protection.
- Throughput: 3 cycles per byte. With grant present, total latency from START to DONE = 3*LEN + 3 cycles.
- RESETN low mid-transfer aborts immediately: bus released, DONE is not pulsed.

Test Plan:
- GNT tied high; RAM preloaded Mem[0x10..0x13]=A1,B2,C3,D4; START SRC=0x10 DST=0x40 LEN=4 -> Mem[0x40..0x43]=A1,B2,C3,D4. DONE is pulsed exactly once, 15 cycles after START. BUS_DATA is never driven by both sides.
- LEN=0 START -> DONE pulses 2 cycles later. BUS_REQ, BUS_WE and BUS_ADDR stay 0 throughout.
- GNT delayed 5 cycles after BUS_REQ -> no bus activity before grant. Copy of 2 bytes correct; DONE is 5 cycles later than the no-wait case.
- GNT dropped during the WR of byte 1 (LEN=3) -> no write issued that cycle. Byte 1 is re-read and rewritten after re-grant; final memory is correct.
- SRC=0xFE, LEN=3 -> reads 0xFE, 0xFF, 0x00 (wrap). The check requires PARK_ADDR to be unmapped in the bench.
- RESETN pulsed low mid-copy -> outputs are immediately 0 and Z, no DONE. A new START afterwards runs normally.
